// File: rtl/dual_phase_counter_if.sv
// Bus bundle for dual_phase_counter: control/limit inputs and counter/status outputs.
// Handshake: start is a single-cycle request with no acknowledge. It is honoured
// on the edge where it is sampled high, unless reset is low on that edge. pause
// and load_w are levels and are sampled on every edge.
interface dual_phase_counter_if #(
  parameter int WIDTH = 4,
  parameter int SUM_W = WIDTH + 1
);
  logic             start;
  logic             pause;
  logic [WIDTH-1:0] lim_a;
  logic [WIDTH-1:0] lim_b;
  logic             load_w;
  logic [SUM_W-1:0] q;
  logic [WIDTH-1:0] cnt_a;
  logic [WIDTH-1:0] cnt_b;
  logic [1:0]       state;
  logic             busy;
  logic             done;

  modport master (
    output start, pause, lim_a, lim_b, load_w,
    input  q, cnt_a, cnt_b, state, busy, done
  );

  modport slave (
    input  start, pause, lim_a, lim_b, load_w,
    output q, cnt_a, cnt_b, state, busy, done
  );
endinterface

// File: rtl/dual_phase_counter.sv
// Two-counter sequencer. A and B count together until B reaches its limit.
// A then counts alone until it reaches its own limit, and the block stops.
// q holds a registered full-width a+b snapshot that is taken on load_w.
module dual_phase_counter #(
  parameter int WIDTH = 4,
  parameter int SUM_W = WIDTH + 1
) (
  input logic                 clk,
  input logic                 reset,
  dual_phase_counter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TOGETHER = 2'd1,
    CNT1     = 2'd2,
    STOP     = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_a_q, cnt_a_d;
  logic [WIDTH-1:0] cnt_b_q, cnt_b_d;
  logic [WIDTH-1:0] lim_a_q, lim_a_d;
  logic [WIDTH-1:0] lim_b_q, lim_b_d;
  logic [SUM_W-1:0] q_q, q_d;

  // State, counters, latched limits and the sum register; reset clears everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      lim_a_q <= '0;
      lim_b_q <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      lim_a_q <= lim_a_d;
      lim_b_q <= lim_b_d;
      q_q     <= q_d;
    end
  end

  // Next-state logic. start beats pause, and pause beats a normal step.
  // The sum load is independent of the FSM.
  always_comb begin
    state_d = state_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    lim_a_d = lim_a_q;
    lim_b_d = lim_b_q;
    q_d     = q_q;

    // The sum uses the counter values from before the edge, even when start clears them.
    if (bus.load_w) begin
      q_d = SUM_W'(cnt_a_q) + SUM_W'(cnt_b_q);
    end

    if (bus.start) begin
      cnt_a_d = '0;
      cnt_b_d = '0;
      lim_a_d = bus.lim_a;
      lim_b_d = bus.lim_b;
      state_d = TOGETHER;
    end else if (!bus.pause) begin
      case (state_q)
        IDLE: state_d = IDLE;
        TOGETHER: begin
          // A always advances here and may wrap when lim_b is all ones.
          cnt_a_d = cnt_a_q + 1'b1;
          if (cnt_b_q == lim_b_q) begin
            state_d = CNT1;
          end else begin
            cnt_b_d = cnt_b_q + 1'b1;
          end
        end
        CNT1: begin
          // >= terminates even when A entered this phase already past its limit.
          if (cnt_a_q >= lim_a_q) begin
            state_d = STOP;
          end else begin
            cnt_a_d = cnt_a_q + 1'b1;
          end
        end
        STOP:    state_d = STOP;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.q     = q_q;
  assign bus.cnt_a = cnt_a_q;
  assign bus.cnt_b = cnt_b_q;
  assign bus.state = state_q;
  assign bus.busy  = (state_q == TOGETHER) || (state_q == CNT1);
  assign bus.done  = (state_q == STOP);

endmodule

// File: tb/tb_dual_phase_counter.sv
// Bench for dual_phase_counter. The expected trajectory comes from the closed-form
// latency description: the number of unpaused edges since start determines
// the phase and the counter values.
module tb_dual_phase_counter;

  logic clk;
  logic rst_n;

  dual_phase_counter_if #(.WIDTH(4), .SUM_W(5)) bus ();

  dual_phase_counter #(.WIDTH(4), .SUM_W(5)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // expected word: {state[2], busy, done, a[4], b[4], q[5]}
  logic [16:0] exp_q[$];

  // model of the current run
  logic [1:0] m_state;
  logic [3:0] m_a, m_b, m_la, m_lb;
  logic [4:0] m_q;
  int         m_k;
  logic       m_active;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {state, a, b} after k unpaused edges since start with limits la, lb.
  function automatic logic [9:0] traj(input int k, input logic [3:0] la, input logic [3:0] lb);
    int ae, fin, s, a;
    ae  = (int'(lb) + 1) % 16;
    fin = (ae >= int'(la)) ? ae : int'(la);
    s   = int'(lb) + 2 + (fin - ae);
    if (k <= int'(lb)) begin
      a = k;
      return {2'd1, a[3:0], a[3:0]};
    end else if (k < s) begin
      a = ae + (k - int'(lb) - 1);
      return {2'd2, a[3:0], lb};
    end else begin
      return {2'd3, fin[3:0], lb};
    end
  endfunction

  // driver: apply one cycle of inputs, push the expectation, then compare after the edge
  task automatic step(input string tag, input logic r, input logic st, input logic ps,
                      input logic ld, input logic [3:0] la, input logic [3:0] lb);
    logic [16:0] got;
    logic [9:0]  t;
    @(negedge clk);
    rst_n      = r;
    bus.start  = st;
    bus.pause  = ps;
    bus.load_w = ld;
    bus.lim_a  = la;
    bus.lim_b  = lb;
    if (!r) begin
      m_state = 2'd0; m_a = 4'd0; m_b = 4'd0; m_q = 5'd0;
      m_la = 4'd0; m_lb = 4'd0; m_k = 0; m_active = 1'b0;
    end else begin
      if (ld) m_q = 5'(m_a) + 5'(m_b);
      if (st) begin
        m_la = la; m_lb = lb; m_k = 0;
        m_a = 4'd0; m_b = 4'd0; m_state = 2'd1; m_active = 1'b1;
      end else if (!ps && m_active) begin
        m_k++;
        t = traj(m_k, m_la, m_lb);
        {m_state, m_a, m_b} = t;
      end
    end
    exp_q.push_back({m_state, (m_state == 2'd1) || (m_state == 2'd2), m_state == 2'd3,
                     m_a, m_b, m_q});
    @(posedge clk);
    #1;
    got = {bus.state, bus.busy, bus.done, bus.cnt_a, bus.cnt_b, bus.q};
    check(tag, 32'(got), 32'(exp_q.pop_front()));
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.pause = 1'b0; bus.load_w = 1'b0;
    bus.lim_a = '0; bus.lim_b = '0;

    // reset state
    step("reset", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    step("reset", 1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 4'd5);
    check("reset_state", 32'(bus.state), 32'd0);
    idle("idle", 2);

    // basic run: lim_b=4, lim_a=9
    step("start_4_9", 1'b1, 1'b1, 1'b0, 1'b0, 4'd9, 4'd4);
    idle("run_4_9", 5);
    check("e5_state", 32'(bus.state), 32'd2);
    check("e5_a", 32'(bus.cnt_a), 32'd5);
    idle("run_4_9", 4);
    check("e9_not_done", 32'(bus.done), 32'd0);
    idle("run_4_9", 1);
    check("e10_done", 32'(bus.done), 32'd1);
    check("e10_a", 32'(bus.cnt_a), 32'd9);
    check("e10_b", 32'(bus.cnt_b), 32'd4);
    step("load_13", 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    check("q_13", 32'(bus.q), 32'd13);

    // zero limits
    step("start_0_0", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    idle("run_0_0", 1);
    check("lb0_state", 32'(bus.state), 32'd2);
    idle("run_0_0", 1);
    check("lb0_stop", 32'(bus.state), 32'd3);
    step("load_1", 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    check("q_1", 32'(bus.q), 32'd1);

    // pause for three cycles at a=b=2, with a load during the pause
    step("start_pause", 1'b1, 1'b1, 1'b0, 1'b0, 4'd9, 4'd4);
    idle("run_pause", 2);
    step("pause", 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    step("pause_ld", 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0);
    step("pause", 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    check("pause_q", 32'(bus.q), 32'd4);
    idle("run_pause", 7);
    check("pause_not_done", 32'(bus.done), 32'd0);
    idle("run_pause", 1);
    check("pause_done", 32'(bus.done), 32'd1);
    check("pause_a", 32'(bus.cnt_a), 32'd9);

    // restart at a=7 in CNT1; pause and load in the same cycle as start
    step("start_rs", 1'b1, 1'b1, 1'b0, 1'b0, 4'd9, 4'd4);
    idle("run_rs", 7);
    check("rs_a7", 32'(bus.cnt_a), 32'd7);
    step("restart", 1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 4'd2);
    check("restart_q", 32'(bus.q), 32'd11);
    check("restart_a", 32'(bus.cnt_a), 32'd0);
    idle("run_restart", 4);
    check("restart_stop", 32'(bus.state), 32'd3);
    check("restart_a3", 32'(bus.cnt_a), 32'd3);

    // reset in mid TOGETHER with start high
    step("start_mr", 1'b1, 1'b1, 1'b0, 1'b0, 4'd12, 4'd9);
    idle("run_mr", 3);
    step("mid_reset", 1'b0, 1'b1, 1'b0, 1'b0, 4'd12, 4'd9);
    check("mr_state", 32'(bus.state), 32'd0);
    idle("after_mr", 3);
    check("mr_idle", 32'(bus.state), 32'd0);

    // wrap: lim_b = lim_a = 15
    step("start_wrap", 1'b1, 1'b1, 1'b0, 1'b0, 4'd15, 4'd15);
    idle("run_wrap", 15);
    check("wrap_b15", 32'(bus.cnt_b), 32'd15);
    idle("run_wrap", 1);
    check("wrap_a0", 32'(bus.cnt_a), 32'd0);
    check("wrap_cnt1", 32'(bus.state), 32'd2);
    idle("run_wrap", 16);
    check("wrap_stop", 32'(bus.state), 32'd3);
    step("load_30", 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    check("q_30", 32'(bus.q), 32'd30);

    // random runs with pause, load, restarts and occasional reset
    for (int r = 0; r < 8; r++) begin
      step("rnd_start", 1'b1, 1'b1, 1'b0, 1'b0,
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      for (int i = 0; i < 45; i++) begin
        step("rnd",
             ($urandom_range(0, 59) != 0),
             ($urandom_range(0, 24) == 0),
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 2) == 0),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dual_phase_counter.md
# dual_phase_counter

Parametrised two-counter sequencer, next generation of the team's counter/register block. Counter A and counter B advance together until B reaches a programmable limit, then A advances alone until it reaches its own limit, then the block stops. Adds start/restart, pause, runtime limits, a registered full-width sum output, and status flags. It sits beside datapath blocks as a programmable event/sequence counter.

## Interface
- WIDTH, 4, width of counters A and B and of the limit inputs
- SUM_W, WIDTH+1, width of q; must be at least WIDTH+1 so a+b never truncates
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset; sampled on rising edge of clk
- start  in  1  one-cycle request: clear counters, latch limits, enter TOGETHER
- pause  in  1  level; freezes counters and state while high
- lim_a  in  WIDTH  end value for counter A; sampled only on start
- lim_b  in  WIDTH  end value for counter B; sampled only on start
- load_w  in  1  when high, q captures a+b at the next edge
- q  out  SUM_W  registered sum; holds between loads
- cnt_a  out  WIDTH  current counter A
- cnt_b  out  WIDTH  current counter B
- state  out  2  IDLE=0, TOGETHER=1, CNT1=2, STOP=3
- busy  out  1  high in TOGETHER or CNT1
- done  out  1  high in STOP

## Operation
- Reset (reset=0 at an edge): state=IDLE, cnt_a=0, cnt_b=0, q=0, latched limits=0; busy=0, done=0. Reset overrides all other inputs, including mid-sequence.
- Priority at each edge: reset > start > pause > normal FSM step.
- start=1 (any state, including mid-sequence): cnt_a=0, cnt_b=0, lim_a_r=lim_a, lim_b_r=lim_b, state=TOGETHER. Restart mid-run is legal and discards progress.
- pause=1 and no start: state, cnt_a, cnt_b hold. load_w still works during pause.
- IDLE: hold until start.
- TOGETHER: if cnt_b == lim_b_r, then cnt_a+1, cnt_b holds, and next state is CNT1. Otherwise cnt_a+1, cnt_b+1, and the state stays TOGETHER.
- CNT1: if cnt_a >= lim_a_r, go to STOP with no increment. Otherwise cnt_a+1 and the state stays CNT1. The >= compare guarantees termination when A already passed lim_a_r on entry.
- STOP: counters hold and done=1. Leave only via start or reset.
- Counters wrap modulo 2^WIDTH. Wrap can only occur in TOGETHER on A when lim_b_r = 2^WIDTH-1. No saturation.
- q: if load_w=1 at an edge, q <= zero-extended cnt_a + cnt_b using pre-edge counter values. Otherwise q holds. load_w is independent of the FSM and is honoured in every state. q is not cleared by start.

## Timing
- All outputs are registered or decoded directly from registers. No combinational path from inputs to outputs.
- Latency from start edge (E0) with lim_b=B, lim_a=A, A>B, no pause:
  - TOGETHER for edges E1..EB, giving a=b=B.
  - Edge E(B+1): a=B+1, state=CNT1.
  - CNT1 increments until a=A at edge E(A).
  - Edge E(A+1): state=STOP. done is first high after E(A+1).
- lim_b=0: the first TOGETHER edge increments A only and moves to CNT1.
- lim_a <= lim_b: on the CNT1 entry edge a=lim_b+1 > lim_a, so the next edge goes to STOP. Final a=lim_b+1.
- Each cycle of pause extends the sequence by exactly one cycle.
- start asserted in the same cycle as pause: start wins.
- start in the same cycle as load_w: q takes the pre-clear a+b.

## Test plan
- Reset, then start with lim_b=4, lim_a=9, WIDTH=4, no pause:
  - state=CNT1 after E5 with a=5, b=4.
  - done after E10 with a=9, b=4.
  - load_w pulse then gives q=13.
- lim_b=0, lim_a=0: after E1 a=1, b=0, state=CNT1; after E2 state=STOP. Then load_w gives q=1.
- Pause high for 3 cycles during TOGETHER at a=b=2: counters hold 3 cycles and done arrives 3 cycles late with final a=9, b=4.
- Restart: start again at a=7 in CNT1 with lim_b=2, lim_a=3: counters clear next edge; STOP after E4 with a=3, b=2.
- reset=0 for one cycle mid-TOGETHER: all outputs zero, state=IDLE, start ignored that cycle. Then the block stays idle until a new start.
- WIDTH=4, lim_b=15, lim_a=15: b reaches 15 at E15 and a is 15. At E16 a wraps to 0 and state=CNT1. CNT1 counts to 15 and STOP follows. load_w gives q=30, no truncation with SUM_W=5.
